csa_pipe_adder: RTL and testbench

- Parametrised, pipelined carry-select adder/subtractor for the datapath ALU.
- The WIDTH-bit operation is split into STAGES equal segments, one segment per pipeline stage. Each segment is built from BLOCK-bit carry-select slices, with carry handed stage to stage.
- Adds a valid/ready handshake with backpressure, subtract mode, and carry/overflow/zero flags.
- Sits between the operand-read stage and the ALU result mux.

---
 rtl/csa_pipe_adder.sv | 239 +++++++++++++++++++++++
 tb/tb_csa_pipe_adder.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/csa_pipe_adder.sv
// csa_pipe_adder: pipelined carry-select adder/subtractor with valid/ready flow control.
// The WIDTH-bit operation is cut into STAGES equal segments, one per pipeline stage.
// Each segment is built from BLOCK-bit carry-select slices, and the carry is registered
// from one stage to the next.
// Optional feature macro: CSA_PIPE_SAT_EN (signed saturation on overflow when sat=1).
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   in_valid / in_ready input handshake; in_ready = ~out_valid | out_ready (combinational)
//   a, b, cin, sub, sat operand bundle (sub: a - b as a + ~b + 1; cin ignored when sub=1)
//   out_valid/out_ready output handshake
//   sum, cout, ovf, zero registered result and flags
module csa_pipe_adder #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned BLOCK  = 4,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    input  logic             sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int unsigned SEG      = WIDTH / STAGES;
    localparam int unsigned NSL      = SEG / BLOCK;
    localparam int unsigned LAST_LSB = (STAGES - 1) * SEG;

    // One segment: ripple slice 0, carry-select for the remaining slices. Returns {cout, sum}.
    function automatic logic [SEG:0] seg_add(input logic [SEG-1:0] x,
                                             input logic [SEG-1:0] y,
                                             input logic           ci);
        logic [SEG-1:0] s;
        logic           c;
        logic [BLOCK:0] r0;
        logic [BLOCK:0] r1;
        s = '0;
        c = ci;
        for (int i = 0; i < int'(BLOCK); i++) begin
            s[i] = x[i] ^ y[i] ^ c;
            c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
        for (int j = 1; j < int'(NSL); j++) begin
            r0 = {1'b0, x[j*BLOCK +: BLOCK]} + {1'b0, y[j*BLOCK +: BLOCK]};
            r1 = {1'b0, x[j*BLOCK +: BLOCK]} + {1'b0, y[j*BLOCK +: BLOCK]} + (BLOCK+1)'(1);
            s[j*BLOCK +: BLOCK] = c ? r1[BLOCK-1:0] : r0[BLOCK-1:0];
            c                   = c ? r1[BLOCK] : r0[BLOCK];
        end
        return {c, s};
    endfunction

    logic [WIDTH-1:0] b_eff_c;
    logic             c0_c;
    logic             adv_c;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    // Inputs to the last stage: either the input bundle or the previous stage register.
    logic             last_v_c;
    logic [WIDTH-1:0] last_a_c;
    logic [WIDTH-1:0] last_b_c;
    logic [WIDTH-1:0] last_s_c;
    logic             last_c_c;
    logic             last_sat_c;

    assign b_eff_c  = sub ? ~b : b;
    assign c0_c     = sub | cin;
    // Whole pipeline advances together; bubbles are carried, not squeezed out.
    assign adv_c    = ~out_valid_q | out_ready;
    assign in_ready = adv_c;

    if (STAGES > 1) begin : g_pipe
        localparam int unsigned NM = STAGES - 1;

        logic [NM-1:0]    v_q, v_d;
        logic [NM-1:0]    c_q, c_d;
        logic [NM-1:0]    sat_q, sat_d;
        logic [WIDTH-1:0] a_q [NM];
        logic [WIDTH-1:0] a_d [NM];
        logic [WIDTH-1:0] b_q [NM];
        logic [WIDTH-1:0] b_d [NM];
        logic [WIDTH-1:0] s_q [NM];
        logic [WIDTH-1:0] s_d [NM];

        logic [NM-1:0]    src_v_c;
        logic [NM-1:0]    src_c_c;
        logic [NM-1:0]    src_sat_c;
        logic [WIDTH-1:0] src_a_c [NM];
        logic [WIDTH-1:0] src_b_c [NM];
        logic [WIDTH-1:0] src_s_c [NM];

        // Predecessor of each non-final stage: the input bundle for stage 0.
        always_comb begin
            src_v_c      = '0;
            src_c_c      = '0;
            src_sat_c    = '0;
            src_a_c[0]   = a;
            src_b_c[0]   = b_eff_c;
            src_s_c[0]   = '0;
            src_v_c[0]   = in_valid;
            src_c_c[0]   = c0_c;
            src_sat_c[0] = sat;
            for (int k = 1; k < int'(NM); k++) begin
                src_a_c[k]   = a_q[k-1];
                src_b_c[k]   = b_q[k-1];
                src_s_c[k]   = s_q[k-1];
                src_v_c[k]   = v_q[k-1];
                src_c_c[k]   = c_q[k-1];
                src_sat_c[k] = sat_q[k-1];
            end
        end

        // Stage k adds segment k; operands ride along whole, completed sum bits accumulate.
        always_comb begin
            logic [SEG:0] r;
            v_d   = v_q;
            c_d   = c_q;
            sat_d = sat_q;
            a_d   = a_q;
            b_d   = b_q;
            s_d   = s_q;
            r     = '0;
            if (adv_c) begin
                for (int k = 0; k < int'(NM); k++) begin
                    r = seg_add(SEG'(src_a_c[k] >> (k * SEG)),
                                SEG'(src_b_c[k] >> (k * SEG)), src_c_c[k]);
                    v_d[k]   = src_v_c[k];
                    c_d[k]   = r[SEG];
                    sat_d[k] = src_sat_c[k];
                    a_d[k]   = src_a_c[k];
                    b_d[k]   = src_b_c[k];
                    s_d[k]   = src_s_c[k] | (WIDTH'(r[SEG-1:0]) << (k * SEG));
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                v_q   <= '0;
                c_q   <= '0;
                sat_q <= '0;
                a_q   <= '{default: '0};
                b_q   <= '{default: '0};
                s_q   <= '{default: '0};
            end else begin
                v_q   <= v_d;
                c_q   <= c_d;
                sat_q <= sat_d;
                a_q   <= a_d;
                b_q   <= b_d;
                s_q   <= s_d;
            end
        end

        assign last_v_c   = v_q[NM-1];
        assign last_c_c   = c_q[NM-1];
        assign last_sat_c = sat_q[NM-1];
        assign last_a_c   = a_q[NM-1];
        assign last_b_c   = b_q[NM-1];
        assign last_s_c   = s_q[NM-1];
    end else begin : g_single
        assign last_v_c   = in_valid;
        assign last_c_c   = c0_c;
        assign last_sat_c = sat;
        assign last_a_c   = a;
        assign last_b_c   = b_eff_c;
        assign last_s_c   = '0;
    end

    // Last stage: final segment, flag generation and optional clamp.
    always_comb begin
        logic [SEG:0]     r;
        logic [WIDTH-1:0] s;
        logic             c_msb;
        logic             ov;
        out_valid_d = out_valid_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        zero_d      = zero_q;
        r     = seg_add(SEG'(last_a_c >> LAST_LSB), SEG'(last_b_c >> LAST_LSB), last_c_c);
        s     = last_s_c | (WIDTH'(r[SEG-1:0]) << LAST_LSB);
        // Carry into the MSB recovered from the MSB sum bit and its operand bits.
        c_msb = s[WIDTH-1] ^ last_a_c[WIDTH-1] ^ last_b_c[WIDTH-1];
        ov    = r[SEG] ^ c_msb;
`ifdef CSA_PIPE_SAT_EN
        // On overflow the true result has operand A's sign.
        if (last_sat_c && ov) begin
            s = last_a_c[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
        if (adv_c) begin
            out_valid_d = last_v_c;
            sum_d       = s;
            cout_d      = r[SEG];
            ovf_d       = ov;
            zero_d      = (s == '0);
        end
    end

`ifndef CSA_PIPE_SAT_EN
    logic unused_sat;
    assign unused_sat = last_sat_c;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;
endmodule

// File: tb/tb_csa_pipe_adder.sv
// Testbench for csa_pipe_adder (WIDTH=32, BLOCK=4, STAGES=2).
module tb_csa_pipe_adder;
    localparam int unsigned ST = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic        sat;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;

    always #5 clk = ~clk;

    csa_pipe_adder #(.WIDTH(32), .BLOCK(4), .STAGES(ST)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .sat(sat),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
    );

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sub;
        logic        sat;
    } bundle_t;

    typedef struct packed {
        logic        cout;
        logic        ovf;
        logic        zero;
        logic [31:0] sum;
    } result_t;

    typedef struct {
        string   name;
        bundle_t in;
        result_t exp;
    } vec_t;

    int          total = 0;
    int          bad   = 0;
    result_t     exp_q[$];
    logic [31:0] got_q[$];
    logic        held_v = 1'b0;
    result_t     held_r;
    bundle_t     cur;
    vec_t        vt[13];

    // Reference: plain 33-bit arithmetic plus the signed-overflow rule on the operand signs.
    function automatic result_t model(input bundle_t bd);
        logic [31:0] bb;
        logic [32:0] full;
        result_t     r;
        bb     = bd.sub ? ~bd.b : bd.b;
        full   = {1'b0, bd.a} + {1'b0, bb} + 33'(bd.sub ? 1'b1 : bd.cin);
        r.sum  = full[31:0];
        r.cout = full[32];
        r.ovf  = (bd.a[31] == bb[31]) && (r.sum[31] != bd.a[31]);
`ifdef CSA_PIPE_SAT_EN
        if (bd.sat && r.ovf) r.sum = bd.a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
        r.zero = (r.sum == 32'd0);
        return r;
    endfunction

    function automatic vec_t mk(input string n, input logic [31:0] va, input logic [31:0] vb,
                                input logic vc, input logic vs, input logic vsat,
                                input logic ec, input logic eo, input logic ez,
                                input logic [31:0] es);
        vec_t v;
        v.name = n;
        v.in   = '{a: va, b: vb, cin: vc, sub: vs, sat: vsat};
        v.exp  = '{cout: ec, ovf: eo, zero: ez, sum: es};
        return v;
    endfunction

    function automatic logic [31:0] rnd32();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    task automatic drive(input bundle_t bd);
        cur = bd;
        a   = bd.a;
        b   = bd.b;
        cin = bd.cin;
        sub = bd.sub;
        sat = bd.sat;
    endtask

    // One clock: sample handshakes just before the rising edge, then step past it.
    task automatic tick(output logic acc);
        result_t e;
        logic    was_rst;
        acc = 1'b0;
        @(negedge clk);
        was_rst = rst;
        if (!rst) begin
            if (held_v) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_sum", sum, held_r.sum);
                check("stall_flags", 32'({cout, ovf, zero}), 32'({held_r.cout, held_r.ovf, held_r.zero}));
            end
            check("in_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
            check("no_spurious", 32'(out_valid && (exp_q.size() == 0)), 32'd0);
            acc = in_valid && in_ready;
            if (acc) exp_q.push_back(model(cur));
            if (out_valid && out_ready && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sb_sum", sum, e.sum);
                check("sb_flags", 32'({cout, ovf, zero}), 32'({e.cout, e.ovf, e.zero}));
                got_q.push_back(sum);
            end
            held_v = out_valid && !out_ready;
            held_r = '{cout: cout, ovf: ovf, zero: zero, sum: sum};
        end else begin
            held_v = 1'b0;
        end
        @(posedge clk);
        if (was_rst) exp_q.delete();
        #1;
    endtask

    task automatic drain();
        logic acc;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 20 && (out_valid || exp_q.size() > 0); c++) tick(acc);
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        check("drain_idle", 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic acc;
        int   nsent;
        int   nacc;

        vt[0]  = mk("add_wrap_zero", 32'h0000_0001, 32'hFFFF_FFFF, 0, 0, 0, 1, 0, 1, 32'h0000_0000);
        vt[1]  = mk("seg_carry",     32'h0000_FFFF, 32'h0000_0001, 0, 0, 0, 0, 0, 0, 32'h0001_0000);
        vt[2]  = mk("cin_ovf",       32'h7FFF_FFFF, 32'h0000_0000, 1, 0, 0, 0, 1, 0, 32'h8000_0000);
        vt[3]  = mk("sub_neg",       32'h0000_0005, 32'h0000_0007, 0, 1, 0, 0, 0, 0, 32'hFFFF_FFFE);
        vt[4]  = mk("sub_pos",       32'h0000_0007, 32'h0000_0005, 0, 1, 0, 1, 0, 0, 32'h0000_0002);
        vt[5]  = mk("sub_cin_ign",   32'h0000_0000, 32'h0000_0000, 1, 1, 0, 1, 0, 1, 32'h0000_0000);
        vt[6]  = mk("sub_ovf",       32'h8000_0000, 32'h0000_0001, 0, 1, 0, 1, 1, 0, 32'h7FFF_FFFF);
        vt[7]  = mk("ones_cin",      32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0, 0, 1, 0, 0, 32'hFFFF_FFFF);
        vt[8]  = mk("neg_ovf_zero",  32'h8000_0000, 32'h8000_0000, 0, 0, 0, 1, 1, 1, 32'h0000_0000);
        vt[9]  = mk("slice_chain",   32'h0F0F_0F0F, 32'h00F0_F0F1, 0, 0, 0, 0, 0, 0, 32'h1000_0000);
        vt[12] = mk("sat_no_ovf",    32'h0000_0001, 32'h0000_0002, 0, 0, 1, 0, 0, 0, 32'h0000_0003);
`ifdef CSA_PIPE_SAT_EN
        vt[10] = mk("sat_pos",       32'h7FFF_FFFF, 32'h0000_0001, 0, 0, 1, 0, 1, 0, 32'h7FFF_FFFF);
        vt[11] = mk("sat_neg",       32'h8000_0000, 32'h0000_0001, 0, 1, 1, 1, 1, 0, 32'h8000_0000);
`else
        vt[10] = mk("sat_pos",       32'h7FFF_FFFF, 32'h0000_0001, 0, 0, 1, 0, 1, 0, 32'h8000_0000);
        vt[11] = mk("sat_neg",       32'h8000_0000, 32'h0000_0001, 0, 1, 1, 1, 1, 0, 32'h7FFF_FFFF);
`endif

        // Reset state.
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drive('0);
        tick(acc);
        tick(acc);
        rst = 1'b0;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum", sum, 32'd0);
        check("rst_flags", 32'({cout, ovf, zero}), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Directed table: one bundle at a time, latency STAGES.
        foreach (vt[i]) begin
            drive(vt[i].in);
            in_valid  = 1'b1;
            out_ready = 1'b1;
            tick(acc);
            check({vt[i].name, "_acc"}, 32'(acc), 32'd1);
            in_valid = 1'b0;
            check({vt[i].name, "_early"}, 32'(out_valid), 32'd0);
            for (int c = 1; c < int'(ST); c++) tick(acc);
            check({vt[i].name, "_valid"}, 32'(out_valid), 32'd1);
            check({vt[i].name, "_sum"}, sum, vt[i].exp.sum);
            check({vt[i].name, "_flags"}, 32'({cout, ovf, zero}),
                  32'({vt[i].exp.cout, vt[i].exp.ovf, vt[i].exp.zero}));
        end
        drain();

        // Backpressure: six back-to-back bundles, consumer stalls in cycles 3-5.
        got_q.delete();
        nsent = 0;
        for (int c = 0; c < 40 && (nsent < 6 || exp_q.size() > 0 || out_valid); c++) begin
            out_ready = !(c >= 3 && c <= 5);
            if (nsent < 6) begin
                drive('{a: 32'(nsent), b: 32'(nsent), cin: 1'b0, sub: 1'b0, sat: 1'b0});
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            tick(acc);
            if (acc) nsent++;
        end
        check("bp_sent", 32'(nsent), 32'd6);
        check("bp_count", 32'(got_q.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < got_q.size()) check("bp_order", got_q[i], 32'(2 * i));
        end
        drain();

        // Reset with two bundles in flight: nothing may come out afterwards.
        got_q.delete();
        out_ready = 1'b0;
        drive('{a: 32'h1111_1111, b: 32'h2222_2222, cin: 1'b0, sub: 1'b0, sat: 1'b0});
        in_valid = 1'b1;
        tick(acc);
        check("mid_acc0", 32'(acc), 32'd1);
        drive('{a: 32'h3333_3333, b: 32'h4444_4444, cin: 1'b1, sub: 1'b0, sat: 1'b0});
        tick(acc);
        check("mid_acc1", 32'(acc), 32'd1);
        check("mid_pending", 32'(out_valid), 32'd1);
        rst      = 1'b1;
        in_valid = 1'b0;
        tick(acc);
        rst = 1'b0;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_sum", sum, 32'd0);
        check("mid_rst_flags", 32'({cout, ovf, zero}), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) tick(acc);
        check("mid_rst_no_stale", 32'(got_q.size()), 32'd0);

        // Random traffic with random consumer stalls; driver holds a bundle until accepted.
        got_q.delete();
        nacc     = 0;
        acc      = 1'b0;
        in_valid = 1'b0;
        for (int c = 0; c < 3000 && nacc < 400; c++) begin
            if (!in_valid || acc) begin
                drive('{a: rnd32(), b: rnd32(), cin: 1'($urandom_range(0, 1)),
                        sub: 1'($urandom_range(0, 1)), sat: 1'($urandom_range(0, 1))});
                in_valid = ($urandom_range(0, 9) < 7);
            end
            out_ready = ($urandom_range(0, 9) < 7);
            tick(acc);
            if (acc) nacc++;
        end
        check("rand_accepted", 32'(nacc), 32'd400);
        drain();
        check("rand_delivered", 32'(got_q.size()), 32'd400);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
